// File: rtl/matvec_tile_sched.sv
// Tile scheduler for y = W*x on the reconfigurable array in MAC mode: walks row tiles outer,
// column tiles inner, chains partial sums through acc_in_vec and streams finished y tiles.
module matvec_tile_sched #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ACC_WIDTH  = 32,
    parameter int unsigned FRAC_BITS  = 8,
    parameter int unsigned TILE_SIZE  = 2,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [CNT_W-1:0]                n_row_tiles,
    input  logic [CNT_W-1:0]                n_col_tiles,
    output logic                            op_req,
    input  logic                            op_ack,
    output logic [CNT_W-1:0]                row_idx,
    output logic [CNT_W-1:0]                col_idx,
    output logic [2:0]                      arr_mode,
    output logic                            arr_valid_in,
    output logic                            arr_accumulate_en,
    output logic [TILE_SIZE*ACC_WIDTH-1:0]  arr_acc_in_vec,
    input  logic                            arr_done_tile,
    input  logic [TILE_SIZE*DATA_WIDTH-1:0] arr_result_vec,
    output logic                            y_valid,
    input  logic                            y_ready,
    output logic [TILE_SIZE*DATA_WIDTH-1:0] y_data,
    output logic [CNT_W-1:0]                y_row_idx,
    output logic                            busy,
    output logic                            done
);

    localparam int unsigned IssW = (TILE_SIZE > 1) ? $clog2(TILE_SIZE) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StIssue,
        StWait,
        StCapture,
        StOut,
        StDone
    } state_e;

    state_e                          state_q;
    logic [CNT_W-1:0]                n_row_q;
    logic [CNT_W-1:0]                n_col_q;
    logic [IssW-1:0]                 issue_cnt_q;
    logic [TILE_SIZE*DATA_WIDTH-1:0] part_q;
    logic [TILE_SIZE*ACC_WIDTH-1:0]  acc_seed;
    logic                            last_col;
    logic                            last_row;

    assign arr_mode = 3'b000;
    assign last_col = (col_idx == n_col_q - CNT_W'(1));
    assign last_row = (row_idx == n_row_q - CNT_W'(1));

    // Q8.8 partial re-expressed at the array's accumulator scale (sign-extended, shifted up).
    always_comb begin
        acc_seed = '0;
        for (int i = 0; i < TILE_SIZE; i++) begin
            acc_seed[i*ACC_WIDTH +: ACC_WIDTH] =
                ACC_WIDTH'($signed(part_q[i*DATA_WIDTH +: DATA_WIDTH])) <<< FRAC_BITS;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= StIdle;
            n_row_q           <= '0;
            n_col_q           <= '0;
            issue_cnt_q       <= '0;
            part_q            <= '0;
            op_req            <= 1'b0;
            row_idx           <= '0;
            col_idx           <= '0;
            arr_valid_in      <= 1'b0;
            arr_accumulate_en <= 1'b0;
            arr_acc_in_vec    <= '0;
            y_valid           <= 1'b0;
            y_data            <= '0;
            y_row_idx         <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        n_row_q <= n_row_tiles;
                        n_col_q <= n_col_tiles;
                        row_idx <= '0;
                        col_idx <= '0;
                        busy    <= 1'b1;
                        if (n_row_tiles == '0 || n_col_tiles == '0) begin
                            state_q <= StDone;
                        end else begin
                            op_req  <= 1'b1;
                            state_q <= StFetch;
                        end
                    end
                end

                StFetch: begin
                    if (op_ack) begin
                        op_req            <= 1'b0;
                        arr_valid_in      <= 1'b1;
                        issue_cnt_q       <= IssW'(TILE_SIZE - 1);
                        arr_accumulate_en <= (col_idx != '0);
                        arr_acc_in_vec    <= (col_idx != '0) ? acc_seed : '0;
                        state_q           <= StIssue;
                    end
                end

                StIssue: begin
                    if (issue_cnt_q == '0) begin
                        arr_valid_in <= 1'b0;
                        state_q      <= StWait;
                    end else begin
                        issue_cnt_q <= issue_cnt_q - IssW'(1);
                    end
                end

                StWait: begin
                    if (arr_done_tile) begin
                        state_q <= StCapture;
                    end
                end

                StCapture: begin
                    part_q <= arr_result_vec;
                    if (last_col) begin
                        y_data    <= arr_result_vec;
                        y_row_idx <= row_idx;
                        y_valid   <= 1'b1;
                        state_q   <= StOut;
                    end else begin
                        col_idx <= col_idx + CNT_W'(1);
                        op_req  <= 1'b1;
                        state_q <= StFetch;
                    end
                end

                StOut: begin
                    if (y_ready) begin
                        y_valid <= 1'b0;
                        if (last_row) begin
                            state_q <= StDone;
                        end else begin
                            row_idx <= row_idx + CNT_W'(1);
                            col_idx <= '0;
                            op_req  <= 1'b1;
                            state_q <= StFetch;
                        end
                    end
                end

                StDone: begin
                    // busy is released by IDLE on the following cycle.
                    done    <= 1'b1;
                    state_q <= StIdle;
                end

                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_matvec_tile_sched.sv
// Bench for matvec_tile_sched: behavioural array/operand environment, table-driven jobs with a
// plain-arithmetic y reference, and hand-written corner-case sequences.
module tb_matvec_tile_sched;

    localparam int DW   = 16;
    localparam int AW   = 32;
    localparam int FB   = 8;
    localparam int TS   = 2;
    localparam int CW   = 8;
    localparam int MAXT = 4;
    localparam int BUDGET = 2000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [CW-1:0] n_row_tiles = '0;
    logic [CW-1:0] n_col_tiles = '0;
    logic op_req, op_ack;
    logic [CW-1:0] row_idx, col_idx, y_row_idx;
    logic [2:0] arr_mode;
    logic arr_valid_in, arr_accumulate_en, arr_done_tile;
    logic [TS*AW-1:0] arr_acc_in_vec;
    logic [TS*DW-1:0] arr_result_vec, y_data;
    logic y_valid, y_ready, busy, done;

    logic env_done;
    logic man_done = 1'b0;
    assign arr_done_tile = env_done | man_done;

    always #5 clk = ~clk;

    matvec_tile_sched #(
        .DATA_WIDTH(DW), .ACC_WIDTH(AW), .FRAC_BITS(FB), .TILE_SIZE(TS), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .n_row_tiles(n_row_tiles), .n_col_tiles(n_col_tiles),
        .op_req(op_req), .op_ack(op_ack), .row_idx(row_idx), .col_idx(col_idx),
        .arr_mode(arr_mode), .arr_valid_in(arr_valid_in),
        .arr_accumulate_en(arr_accumulate_en), .arr_acc_in_vec(arr_acc_in_vec),
        .arr_done_tile(arr_done_tile), .arr_result_vec(arr_result_vec),
        .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .y_row_idx(y_row_idx),
        .busy(busy), .done(done)
    );

    // Operands (Q8.8) the environment "fetches" for each tile.
    logic signed [DW-1:0] wm [MAXT*TS][MAXT*TS];
    logic signed [DW-1:0] xv [MAXT*TS];

    // Controls written by the test, read by the environment.
    logic ack_hold = 1'b0;
    logic ready_force = 1'b0;
    logic ready_val = 1'b1;
    int   hold_col = -1;

    // Observations recorded by the environment.
    int n_ack = 0, n_valid = 0, n_y = 0, n_done = 0, n_opreq = 0;
    longint ack_log[$], y_log[$], yr_log[$], en_log[$], acc_log[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Environment: operand fetch, behavioural MAC array, y consumer, monitors.
    initial begin : env
        int vc, lat, ack_dly, cap_r, cap_c;
        logic cap_en;
        logic [TS*AW-1:0] cap_acc;
        longint s;
        vc = 0; lat = 0; ack_dly = -1; cap_r = 0; cap_c = 0; cap_en = 1'b0; cap_acc = '0;
        op_ack = 1'b0; env_done = 1'b0; y_ready = 1'b1; arr_result_vec = '0;
        forever begin
            @(posedge clk);
            #1;
            op_ack = 1'b0;
            env_done = 1'b0;
            if (rst) begin
                vc = 0; lat = 0; ack_dly = -1;
            end else begin
                if (op_req) n_opreq++;
                if (op_req && !ack_hold) begin
                    if (ack_dly < 0) ack_dly = int'($urandom_range(0, 2));
                    if (ack_dly == 0) begin
                        op_ack = 1'b1;
                        ack_dly = -1;
                        n_ack++;
                        ack_log.push_back(longint'(row_idx) * 256 + longint'(col_idx));
                    end else begin
                        ack_dly--;
                    end
                end
                if (arr_valid_in) begin
                    if (vc == 0) begin
                        cap_en = arr_accumulate_en; cap_acc = arr_acc_in_vec;
                        cap_r = int'(row_idx); cap_c = int'(col_idx);
                        en_log.push_back(longint'(cap_en));
                        acc_log.push_back(longint'(cap_acc));
                    end
                    n_valid++;
                    vc++;
                    if (vc == TS) begin
                        vc = 0;
                        lat = 2 + int'($urandom_range(0, 2));
                    end
                end else if (lat > 0) begin
                    lat--;
                    if (lat == 0 && cap_c != hold_col) begin
                        for (int i = 0; i < TS; i++) begin
                            s = cap_en ? longint'($signed(cap_acc[i*AW +: AW])) : 64'sd0;
                            for (int j = 0; j < TS; j++)
                                s += longint'(wm[cap_r*TS+i][cap_c*TS+j]) * longint'(xv[cap_c*TS+j]);
                            arr_result_vec[i*DW +: DW] = DW'(s >>> FB);
                        end
                        env_done = 1'b1;
                    end
                end
                y_ready = ready_force ? ready_val : ($urandom_range(0, 3) != 0);
                if (y_valid && y_ready) begin
                    n_y++;
                    y_log.push_back(longint'(y_data));
                    yr_log.push_back(longint'(y_row_idx));
                end
                if (done) n_done++;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic longint log_at(input int which, input int i);
        case (which)
            0: return (i >= 0 && i < ack_log.size()) ? ack_log[i] : -1;
            1: return (i >= 0 && i < y_log.size()) ? y_log[i] : -1;
            2: return (i >= 0 && i < yr_log.size()) ? yr_log[i] : -1;
            3: return (i >= 0 && i < en_log.size()) ? en_log[i] : -1;
            default: return (i >= 0 && i < acc_log.size()) ? acc_log[i] : -1;
        endcase
    endfunction

    // Reference y element: partial sums carried across column tiles in Q8.8.
    function automatic logic [DW-1:0] ref_y(input int r, input int i, input int nc);
        logic [DW-1:0] p;
        longint acc;
        p = '0;
        for (int c = 0; c < nc; c++) begin
            acc = (c == 0) ? 64'sd0 : longint'($signed(p)) * 256;
            for (int j = 0; j < TS; j++)
                acc += longint'(wm[r*TS+i][c*TS+j]) * longint'(xv[c*TS+j]);
            p = DW'(acc >>> FB);
        end
        return p;
    endfunction

    function automatic longint ref_tile(input int r, input int nc);
        logic [TS*DW-1:0] v;
        for (int i = 0; i < TS; i++) v[i*DW +: DW] = ref_y(r, i, nc);
        return longint'(v);
    endfunction

    task automatic rand_mats();
        for (int r = 0; r < MAXT*TS; r++) begin
            xv[r] = DW'(int'($urandom_range(0, 1023)) - 512);
            for (int c = 0; c < MAXT*TS; c++) wm[r][c] = DW'(int'($urandom_range(0, 1023)) - 512);
        end
    endtask

    task automatic load_t1();
        for (int r = 0; r < MAXT*TS; r++) begin
            xv[r] = '0;
            for (int c = 0; c < MAXT*TS; c++) wm[r][c] = '0;
        end
        for (int c = 0; c < 4; c++) begin
            wm[0][c] = DW'(256 * (c + 1));
            wm[1][c] = DW'(256 * (c + 5));
            xv[c]    = DW'(256 * (c + 1));
        end
    endtask

    task automatic start_job(input int nr, input int nc);
        n_row_tiles = CW'(nr);
        n_col_tiles = CW'(nc);
        start = 1'b1;
        cyc();
        start = 1'b0;
        n_row_tiles = CW'($urandom);
        n_col_tiles = CW'($urandom);
    endtask

    task automatic wait_done(input string tag, input int d0);
        int t;
        t = 0;
        while (n_done == d0 && t < BUDGET) begin
            cyc();
            t++;
        end
        repeat (3) cyc();
        chk({tag, " done pulses"}, n_done - d0, 1);
        chk({tag, " busy after"}, busy, 0);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " op_req"}, op_req, 0);
        chk({tag, " valid_in"}, arr_valid_in, 0);
        chk({tag, " acc_en"}, arr_accumulate_en, 0);
        chk({tag, " acc_in"}, longint'(arr_acc_in_vec), 0);
        chk({tag, " y_valid"}, y_valid, 0);
        chk({tag, " y_data"}, y_data, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " row_idx"}, row_idx, 0);
        chk({tag, " col_idx"}, col_idx, 0);
    endtask

    typedef struct {
        int nr;
        int nc;
        int acks;
        int valids;
        int ys;
    } vec_t;

    initial begin : test
        vec_t tbl[7];
        int a0, v0, y0, d0, e0, o0, t, k;
        tbl[0] = '{1, 2, 2, 4, 1};
        tbl[1] = '{2, 3, 6, 12, 2};
        tbl[2] = '{3, 1, 3, 6, 3};
        tbl[3] = '{1, 1, 1, 2, 1};
        tbl[4] = '{0, 3, 0, 0, 0};
        tbl[5] = '{2, 0, 0, 0, 0};
        tbl[6] = '{4, 4, 16, 32, 4};

        load_t1();
        repeat (3) cyc();
        check_idle("reset");
        chk("arr_mode", arr_mode, 0);
        rst = 1'b0;
        cyc();

        // Single-tile chain with known operands.
        e0 = acc_log.size(); y0 = n_y; d0 = n_done;
        start_job(1, 2);
        wait_done("t1", d0);
        chk("t1 tile0 acc_en", log_at(3, e0), 0);
        chk("t1 tile0 acc_in", log_at(4, e0), 0);
        chk("t1 tile1 acc_en", log_at(3, e0 + 1), 1);
        chk("t1 tile1 acc_in", log_at(4, e0 + 1), 64'h0011_0000_0005_0000);
        chk("t1 y count", n_y - y0, 1);
        chk("t1 y_data", log_at(1, y0), 64'h4600_1E00);
        chk("t1 y_row", log_at(2, y0), 0);

        // Table of random jobs against the reference model.
        foreach (tbl[n]) begin
            rand_mats();
            a0 = n_ack; v0 = n_valid; y0 = n_y; d0 = n_done;
            start_job(tbl[n].nr, tbl[n].nc);
            wait_done($sformatf("job%0d", n), d0);
            chk($sformatf("job%0d acks", n), n_ack - a0, tbl[n].acks);
            chk($sformatf("job%0d valid cycles", n), n_valid - v0, tbl[n].valids);
            chk($sformatf("job%0d y transfers", n), n_y - y0, tbl[n].ys);
            k = 0;
            for (int r = 0; r < tbl[n].nr; r++) begin
                for (int c = 0; c < tbl[n].nc; c++) begin
                    chk($sformatf("job%0d order %0d", n, k), log_at(0, a0 + k), r * 256 + c);
                    k++;
                end
                if (tbl[n].nc > 0) begin
                    chk($sformatf("job%0d y %0d", n, r), log_at(1, y0 + r), ref_tile(r, tbl[n].nc));
                    chk($sformatf("job%0d y_row %0d", n, r), log_at(2, y0 + r), r);
                end
            end
        end

        // Backpressure on the first row tile.
        rand_mats();
        ready_force = 1'b1; ready_val = 1'b0;
        y0 = n_y; d0 = n_done;
        start_job(2, 1);
        t = 0;
        while (!y_valid && t < BUDGET) begin
            cyc();
            t++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("bp y_valid", y_valid, 1);
            chk("bp y_data", y_data, ref_tile(0, 1));
            chk("bp op_req", op_req, 0);
            chk("bp row_idx", row_idx, 0);
            chk("bp no transfer", n_y - y0, 0);
            cyc();
        end
        ready_val = 1'b1;
        cyc();
        chk("bp one transfer", n_y - y0, 1);
        cyc();
        chk("bp y_valid drop", y_valid, 0);
        wait_done("bp", d0);
        chk("bp y total", n_y - y0, 2);
        chk("bp row1 y", log_at(1, y0 + 1), ref_tile(1, 1));
        ready_force = 1'b0;

        // Zero column count: only a done pulse two cycles after start.
        o0 = n_opreq; v0 = n_valid; d0 = n_done;
        chk("zero T busy", busy, 0);
        n_row_tiles = 8'd3; n_col_tiles = 8'd0; start = 1'b1;
        cyc();
        start = 1'b0;
        chk("zero T+1 busy", busy, 1);
        chk("zero T+1 done", done, 0);
        cyc();
        chk("zero T+2 busy", busy, 1);
        chk("zero T+2 done", done, 1);
        cyc();
        chk("zero T+3 busy", busy, 0);
        chk("zero T+3 done", done, 0);
        repeat (3) cyc();
        chk("zero op_req", n_opreq - o0, 0);
        chk("zero valid_in", n_valid - v0, 0);
        chk("zero done count", n_done - d0, 1);

        // Reset while waiting on the second column tile, then a stray done_tile.
        load_t1();
        hold_col = 1;
        v0 = n_valid; d0 = n_done;
        start_job(1, 2);
        t = 0;
        while ((n_valid - v0 < 4 || arr_valid_in) && t < BUDGET) begin
            cyc();
            t++;
        end
        repeat (2) cyc();
        chk("rst pre col_idx", col_idx, 1);
        chk("rst pre acc_en", arr_accumulate_en, 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check_idle("rst");
        man_done = 1'b1;
        cyc();
        man_done = 1'b0;
        repeat (3) cyc();
        check_idle("rst stray");
        chk("rst no done", n_done - d0, 0);
        hold_col = -1;
        y0 = n_y; d0 = n_done;
        start_job(1, 2);
        wait_done("rst rerun", d0);
        chk("rst rerun y", log_at(1, y0), 64'h4600_1E00);

        // Negative partial, stray done_tile in FETCH, start while busy.
        rand_mats();
        wm[0][0] = 16'hFF00; wm[0][1] = 16'h0000; xv[0] = 16'h0100;
        ack_hold = 1'b1;
        a0 = n_ack; v0 = n_valid; d0 = n_done; e0 = acc_log.size(); y0 = n_y;
        start_job(1, 2);
        t = 0;
        while (!op_req && t < BUDGET) begin
            cyc();
            t++;
        end
        man_done = 1'b1;
        cyc();
        man_done = 1'b0;
        repeat (3) cyc();
        chk("stray op_req held", op_req, 1);
        chk("stray no valid_in", n_valid - v0, 0);
        ack_hold = 1'b0;
        t = 0;
        while (n_ack == a0 && t < BUDGET) begin
            cyc();
            t++;
        end
        start = 1'b1;
        cyc();
        start = 1'b0;
        wait_done("sign", d0);
        chk("sign acks", n_ack - a0, 2);
        chk("sign acc_in elem0", log_at(4, e0 + 1) & 64'hFFFF_FFFF, 64'hFFFF_0000);
        chk("sign acc_en", log_at(3, e0 + 1), 1);
        chk("sign y", log_at(1, y0), ref_tile(0, 2));
        repeat (4) cyc();
        chk("busy start ignored", n_done - d0, 1);
        chk("busy start no acks", n_ack - a0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/matvec_tile_sched.md
Name: matvec_tile_sched

Overview:
Sequences a tiled matrix-vector multiply y = W·x on recfg_array_new in MAC mode (mode=3'b000). Walks row tiles (outer) and column tiles (inner), fetches operands through a request/ack handshake, and drives valid_in and accumulate_en on the array. Holds the partial sum of each row tile across column tiles and feeds it back as acc_in_vec, then emits each finished y tile over a valid/ready port. It replaces manual per-tile sequencing of the array.

Parameters:
DATA_WIDTH, 16, operand/result width (Q8.8)
ACC_WIDTH, 32, accumulator width of acc_in_vec
FRAC_BITS, 8, fractional bits
TILE_SIZE, 2, array tile dimension
CNT_W, 8, width of tile counts/indices

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start  in  1  job request, sampled only in IDLE
n_row_tiles  in  CNT_W  number of row tiles (OUT_SIZE/TILE_SIZE), sampled at start
n_col_tiles  in  CNT_W  number of column tiles (D_INNER/TILE_SIZE), sampled at start
op_req  out  1  operand fetch request for tile (row_idx, col_idx)
op_ack  in  1  operands are present on the array a_in/b_vec inputs and stay stable until the next op_req
row_idx  out  CNT_W  current row tile
col_idx  out  CNT_W  current column tile
arr_mode  out  3  constant 3'b000
arr_valid_in  out  1  to array valid_in
arr_accumulate_en  out  1  to array accumulate_en
arr_acc_in_vec  out  TILE_SIZE*ACC_WIDTH  flattened; element i at [i*ACC_WIDTH +: ACC_WIDTH]
arr_done_tile  in  1  from array done_tile
arr_result_vec  in  TILE_SIZE*DATA_WIDTH  flattened result_out_vec
y_valid  out  1  finished row tile available
y_ready  in  1  consumer accepts the y tile
y_data  out  TILE_SIZE*DATA_WIDTH  finished y tile
y_row_idx  out  CNT_W  row tile index of y_data
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at job end

Behaviour:
- Reset: state is IDLE. All outputs are 0: op_req, arr_valid_in, arr_accumulate_en, arr_acc_in_vec, y_valid, y_data, busy, done, row_idx, col_idx. The partial buffer clears to 0.
- Reset wins over every other event. Asserting it mid-job discards the job; an arr_done_tile arriving later is ignored.
- States: IDLE, FETCH, ISSUE, WAIT, CAPTURE, OUT, DONE.
- IDLE: when start=1, latch the tile counts and set row=col=0.
  - If either count is 0, go to DONE.
  - Otherwise go to FETCH.
- FETCH: op_req=1. On op_ack=1, go to ISSUE (op_req drops the same edge).
  - arr_accumulate_en = (col_idx != 0).
  - arr_acc_in_vec[i] = col_idx==0 ? 0 : sign_extend(buf[i]) <<< FRAC_BITS.
  - Both are registered and stay stable from the FETCH exit until the CAPTURE exit.
- ISSUE: arr_valid_in=1 for exactly TILE_SIZE consecutive cycles (down-counter), then go to WAIT.
- WAIT: hold until arr_done_tile=1, then go to CAPTURE. arr_done_tile is ignored in every other state.
- CAPTURE (1 cycle): buf <= arr_result_vec.
  - If col_idx is the last column tile: go to OUT, with y_data <= arr_result_vec and y_row_idx <= row_idx.
  - Otherwise: col_idx+1, go to FETCH.
- OUT: y_valid=1 with y_data stable until y_ready=1; the transfer completes on that edge.
  - If row_idx is the last row tile, go to DONE.
  - Otherwise row_idx+1, col_idx=0, go to FETCH.
- DONE: done=1 for one cycle, then go to IDLE. busy=0 from IDLE onward.
- start outside IDLE is ignored. Count inputs are not re-sampled mid-job.
- Tile order per job: (0,0),(0,1)..(0,C-1),(1,0)... Exactly R*C op_req acks and R*C*TILE_SIZE arr_valid_in cycles per job.
- Index counters do not wrap within a job; the maximum count is 2^CNT_W-1.

Test Plan:
1. Single tile chain. Use the real recfg_array_new with TILE_SIZE=2, n_row=1, n_col=2, W=[1 2 3 4;5 6 7 8], x=[1 2 3 4] (Q8.8).
   - Tile 0: accumulate_en=0, acc_in=0.
   - Tile 1: accumulate_en=1, acc_in = tile0 result <<< 8.
   - Required: a single y_valid with y_data=[7680,17920], y_row_idx=0, then done.
2. Iteration order. Behavioural array model, n_row=2, n_col=3.
   - Required: (row,col) sequence (0,0),(0,1),(0,2),(1,0),(1,1),(1,2).
   - Required: 6 acks, 12 arr_valid_in cycles, 2 y_valid transfers, 1 done pulse.
3. Backpressure. Hold y_ready=0 for 5 cycles in OUT.
   - Required: y_valid and y_data stable, no op_req, row_idx unchanged.
   - Required: one transfer when y_ready rises.
4. Zero dimension. n_col_tiles=0 with start at cycle T.
   - Required: done=1 at cycle T+2 and only then; no op_req or arr_valid_in ever.
   - Required: busy=1 only at T+1..T+2.
5. Reset mid-job. Assert rst during WAIT, then pulse arr_done_tile.
   - Required: all outputs 0 and no reaction to done_tile.
   - Required: a fresh start completes scenario 1 correctly.
6. Sign and stray inputs.
   - Partial result 0xFF00 (-1.0) -> next arr_acc_in_vec element 0xFFFF0000.
   - start pulsed while busy -> ignored.
   - arr_done_tile pulsed in FETCH -> ignored.
